// File: rtl/stack_unwinder.sv
// Unwinds a downstream operand stack to a frame base, re-pushing up to three
// top-of-stack results so they end up at base..base+arity-1 in original order.
module stack_unwinder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DEPTH:0]     base,
    input  logic [1:0]         arity,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [2:0]         stk_op,
    output logic [WIDTH-1:0]   stk_data,
    output logic [DEPTH:0]     stk_new_index,
    input  logic [DEPTH:0]     stk_index,
    input  logic [WIDTH-1:0]   stk_out,
    input  logic [WIDTH-1:0]   stk_out1,
    input  logic [WIDTH-1:0]   stk_out2,
    input  logic [2:0]         stk_status
);

    localparam int unsigned CW = DEPTH + 2;

    localparam logic [2:0] OP_NONE                 = 3'd0;
    localparam logic [2:0] OP_PUSH                 = 3'd1;
    localparam logic [2:0] OP_INDEX_RESET          = 3'd4;
    localparam logic [2:0] OP_INDEX_RESET_AND_PUSH = 3'd5;

    localparam logic [2:0] STATUS_BAD_INDEX        = 3'd2;
    localparam logic [2:0] STATUS_OVERFLOW         = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_CAPTURE,
        S_RESET,
        S_PUSH,
        S_CHECK
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [DEPTH:0]     r_base;
    logic [1:0]         r_arity;
    logic [WIDTH-1:0]   r_res0;
    logic [WIDTH-1:0]   r_res1;
    logic [WIDTH-1:0]   r_res2;
    logic [1:0]         r_left;
    logic [1:0]         w_left_nxt;
    logic               r_fail;
    logic               w_fail_nxt;

    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic               w_error_nxt;
    logic [2:0]         r_stk_op;
    logic [2:0]         w_op_nxt;
    logic [WIDTH-1:0]   r_stk_data;
    logic [WIDTH-1:0]   w_data_nxt;
    logic [DEPTH:0]     r_stk_new_index;
    logic [DEPTH:0]     w_nidx_nxt;

    logic [CW-1:0]      w_need;
    logic               w_short;
    logic               w_status_bad;
    logic               w_check_err;

    // Stack must hold at least base+arity entries for the unwind to be legal.
    assign w_need       = CW'(r_base) + CW'(r_arity);
    assign w_short      = CW'(stk_index) < w_need;
    assign w_status_bad = (stk_status == STATUS_BAD_INDEX) || (stk_status == STATUS_OVERFLOW);
    // Status reflects the last issued op only in CHECK; a short stack never touched it.
    assign w_check_err  = (r_state == S_CHECK) && !r_fail && w_status_bad;

    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error | w_check_err;
    assign stk_op        = r_stk_op;
    assign stk_data      = r_stk_data;
    assign stk_new_index = r_stk_new_index;

    always_comb begin
        w_state_nxt = r_state;
        w_left_nxt  = r_left;
        w_fail_nxt  = r_fail;
        w_error_nxt = r_error;
        w_op_nxt    = OP_NONE;
        w_data_nxt  = '0;
        w_nidx_nxt  = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SAMPLE;
                    w_fail_nxt  = 1'b0;
                    w_error_nxt = 1'b0;
                end
            end
            S_SAMPLE: begin
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (w_short) begin
                    w_state_nxt = S_CHECK;
                    w_fail_nxt  = 1'b1;
                    w_error_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_RESET;
                    w_nidx_nxt  = r_base;
                    w_left_nxt  = (r_arity == 2'd0) ? 2'd0 : r_arity - 2'd1;
                    // Deepest preserved result goes out with the index reset.
                    case (r_arity)
                        2'd0: w_op_nxt = OP_INDEX_RESET;
                        2'd1: begin
                            w_op_nxt   = OP_INDEX_RESET_AND_PUSH;
                            w_data_nxt = stk_out;
                        end
                        2'd2: begin
                            w_op_nxt   = OP_INDEX_RESET_AND_PUSH;
                            w_data_nxt = stk_out1;
                        end
                        default: begin
                            w_op_nxt   = OP_INDEX_RESET_AND_PUSH;
                            w_data_nxt = stk_out2;
                        end
                    endcase
                end
            end
            S_RESET, S_PUSH: begin
                if (r_left != 2'd0) begin
                    w_state_nxt = S_PUSH;
                    w_op_nxt    = OP_PUSH;
                    w_data_nxt  = (r_left == 2'd2) ? r_res1 : r_res0;
                    w_left_nxt  = r_left - 2'd1;
                end else begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                w_state_nxt = S_IDLE;
                w_error_nxt = r_error | w_check_err;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_base          <= '0;
            r_arity         <= '0;
            r_res0          <= '0;
            r_res1          <= '0;
            r_res2          <= '0;
            r_left          <= '0;
            r_fail          <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
            r_stk_op        <= OP_NONE;
            r_stk_data      <= '0;
            r_stk_new_index <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_left          <= w_left_nxt;
            r_fail          <= w_fail_nxt;
            r_busy          <= (w_state_nxt != S_IDLE);
            r_done          <= (w_state_nxt == S_CHECK);
            r_error         <= w_error_nxt;
            r_stk_op        <= w_op_nxt;
            r_stk_data      <= w_data_nxt;
            r_stk_new_index <= w_nidx_nxt;
            if ((r_state == S_IDLE) && start) begin
                r_base  <= base;
                r_arity <= arity;
            end
            if (r_state == S_CAPTURE) begin
                r_res0 <= stk_out;
                r_res1 <= stk_out1;
                r_res2 <= stk_out2;
            end
        end
    end

endmodule
